// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: shares one single-port synchronous ROM between N_REQ read
// requesters. Each requester gets a one-cycle grant pulse, the ROM address is
// registered on that grant, and the read data comes back one cycle later
// tagged with a one-hot rvalid strobe.
//
// Build option: define ROM_ARB_FIXED_PRIO_EN for fixed priority, where the
// lowest-index eligible requester always wins and there is no round-robin
// pointer. Without it, the arbiter is round-robin.
module rom_read_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  vld_q, vld_d;
    logic [ADDR_W-1:0] rom_address_q, rom_address_d;
    logic [N_REQ-1:0]  elig;
    logic              found;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  base_ptr;

`ifdef ROM_ARB_FIXED_PRIO_EN
    // Fixed priority always scans from requester 0.
    assign base_ptr = '0;
`else
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

    assign base_ptr = rr_ptr_q;
`endif

    // Pick the first eligible requester at or above base_ptr, wrapping around.
    // The requester holding this cycle's grant is masked so that its
    // still-high req is not served twice.
    always_comb begin
        elig    = req & ~gnt_q;
        found   = 1'b0;
        win_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && elig[(int'(base_ptr) + k) % N_REQ]) begin
                found   = 1'b1;
                win_idx = PTR_W'((int'(base_ptr) + k) % N_REQ);
            end
        end
    end

    // Next-state logic: register the winner's grant and address; vld follows gnt.
    always_comb begin
        gnt_d         = '0;
        rom_address_d = rom_address_q;
        vld_d         = gnt_q;
`ifndef ROM_ARB_FIXED_PRIO_EN
        rr_ptr_d      = rr_ptr_q;
`endif
        if (found) begin
            gnt_d         = N_REQ'(1) << win_idx;
            rom_address_d = addr[int'(win_idx)*ADDR_W +: ADDR_W];
`ifndef ROM_ARB_FIXED_PRIO_EN
            rr_ptr_d      = PTR_W'((int'(win_idx) + 1) % N_REQ);
`endif
        end
    end

    // State registers. Reset clears vld, so a read in flight at reset gets no rvalid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_q         <= '0;
            vld_q         <= '0;
            rom_address_q <= '0;
`ifndef ROM_ARB_FIXED_PRIO_EN
            rr_ptr_q      <= '0;
`endif
        end else begin
            gnt_q         <= gnt_d;
            vld_q         <= vld_d;
            rom_address_q <= rom_address_d;
`ifndef ROM_ARB_FIXED_PRIO_EN
            rr_ptr_q      <= rr_ptr_d;
`endif
        end
    end

    assign gnt         = gnt_q;
    assign rvalid      = vld_q;
    assign rom_address = rom_address_q;
    assign rdata       = (|vld_q) ? rom_q : '0;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Testbench for rom_read_arbiter: directed cases plus randomized traffic,
// with a scoreboard fed by a reference model of the arbitration rules.
module tb_rom_read_arbiter;

`ifdef ROM_ARB_FIXED_PRIO_EN
    localparam int N = 3;
`else
    localparam int N = 2;
`endif
    localparam int AW = 5;
    localparam int DW = 8;

    logic              clk;
    logic              reset_n;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   addr;
    logic [N-1:0]      gnt;
    logic [N-1:0]      rvalid;
    logic [DW-1:0]     rdata;
    logic [AW-1:0]     rom_address;
    logic [DW-1:0]     rom_q;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int           cyc;
        logic [N-1:0] g;
        logic [AW-1:0] a;
    } gexp_t;

    typedef struct {
        int           cyc;
        logic [N-1:0] v;
        logic [DW-1:0] d;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];

    // reference model state: grant shown in the current cycle, previous cycle, priority start
    logic [N-1:0] m_gnt;
    logic [N-1:0] m_gnt_prev;
    int           m_ptr;

    rom_read_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .addr        (addr),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .rom_address (rom_address),
        .rom_q       (rom_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: q = address ^ 8'hA5, one cycle of latency
    always @(posedge clk) rom_q <= {3'b000, rom_address} ^ 8'hA5;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] elig, input int start);
        for (int k = 0; k < N; k++) begin
            if (elig[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    // Given the req/addr driven in this cycle, predict the grant at the next edge
    // and the read data one cycle after that.
    task automatic model_step();
        logic [N-1:0] elig;
        logic [N-1:0] nxt;
        logic [AW-1:0] a;
        int w;
        elig = req & ~m_gnt;
`ifdef ROM_ARB_FIXED_PRIO_EN
        w = pick(elig, 0);
`else
        w = pick(elig, m_ptr);
`endif
        nxt = '0;
        if (w >= 0) begin
            nxt   = N'(1) << w;
            a     = addr[w*AW +: AW];
            m_ptr = (w + 1) % N;
            gq.push_back('{cyc + 1, nxt, a});
            rq.push_back('{cyc + 2, nxt, {3'b000, a} ^ 8'hA5});
        end
        m_gnt_prev = m_gnt;
        m_gnt      = nxt;
    endtask

    task automatic model_reset();
        gq.delete();
        rq.delete();
        m_gnt      = '0;
        m_gnt_prev = '0;
        m_ptr      = 0;
        req        = '0;
        addr       = '0;
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        @(posedge clk);
        #1;
        req           = r;
        addr          = '0;
        addr[0 +: AW] = a0;
        addr[AW +: AW] = a1;
        model_step();
    endtask

    // Random requester behaviour obeying the req-hold contract.
    task automatic rand_cycle(input bit allow_new);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (m_gnt_prev[i] || (!req[i] && !m_gnt[i])) begin
                req[i] = allow_new ? 1'($urandom_range(0, 1)) : 1'b0;
                addr[i*AW +: AW] = AW'($urandom_range(0, 31));
            end
        end
        model_step();
    endtask

    // Scoreboard monitor: compare DUT outputs against the expected queues every cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            while (gq.size() > 0 && gq[0].cyc < cyc) begin
                chk("gnt_missing", 32'(gq[0].cyc), 32'(cyc));
                void'(gq.pop_front());
            end
            if (gq.size() > 0 && gq[0].cyc == cyc) begin
                gexp_t e;
                e = gq.pop_front();
                chk("sb_gnt", 32'(gnt), 32'(e.g));
                chk("sb_rom_address", 32'(rom_address), 32'(e.a));
            end else begin
                chk("sb_idle_gnt", 32'(gnt), 32'h0);
            end
            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                chk("rvalid_missing", 32'(rq[0].cyc), 32'(cyc));
                void'(rq.pop_front());
            end
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
                rexp_t e;
                e = rq.pop_front();
                chk("sb_rvalid", 32'(rvalid), 32'(e.v));
                chk("sb_rdata", 32'(rdata), 32'(e.d));
            end else begin
                chk("sb_idle_rvalid", 32'(rvalid), 32'h0);
                chk("sb_idle_rdata", 32'(rdata), 32'h0);
            end
        end
    end

    initial begin
        logic [N-1:0] prev_g;
        reset_n = 1'b0;
        model_reset();
        #3;
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_rvalid", 32'(rvalid), 32'h0);
        chk("reset_rdata", 32'(rdata), 32'h0);
        chk("reset_rom_address", 32'(rom_address), 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // contention: addr0=3, addr1=20
        drive(N'(3), 5'd3, 5'd20);
        drive(N'(3), 5'd3, 5'd20);
        chk("cont_gnt0", 32'(gnt), 32'h1);
        chk("cont_addr0", 32'(rom_address), 32'd3);
        drive(N'(2), 5'd0, 5'd20);
        chk("cont_gnt1", 32'(gnt), 32'h2);
        chk("cont_addr1", 32'(rom_address), 32'd20);
        chk("cont_rvalid0", 32'(rvalid), 32'h1);
        chk("cont_rdata0", 32'(rdata), 32'hA6);
        drive(N'(0), 5'd0, 5'd0);
        chk("cont_rvalid1", 32'(rvalid), 32'h2);
        chk("cont_rdata1", 32'(rdata), 32'hB1);
        chk("cont_gnt_end", 32'(gnt), 32'h0);

        // single request, addr0=7
        drive(N'(1), 5'd7, 5'd0);
        drive(N'(1), 5'd7, 5'd0);
        chk("single_gnt", 32'(gnt), 32'h1);
        chk("single_addr", 32'(rom_address), 32'd7);
        drive(N'(0), 5'd0, 5'd0);
        chk("single_rvalid", 32'(rvalid), 32'h1);
        chk("single_rdata", 32'(rdata), 32'hA2);
        chk("single_gnt_after", 32'(gnt), 32'h0);
        drive(N'(0), 5'd0, 5'd0);
        chk("single_idle_gnt", 32'(gnt), 32'h0);
        chk("single_idle_rvalid", 32'(rvalid), 32'h0);
        chk("single_idle_rdata", 32'(rdata), 32'h0);

        // continuous contention: req[1:0] held high
        prev_g = '0;
        for (int i = 0; i < 11; i++) begin
            drive(N'(3), 5'd10, 5'd11);
            if (i >= 1) begin
                chk("cont_onehot", 32'($countones(gnt)), 32'd1);
                chk("cont_low_bits", 32'(gnt & N'(3)), 32'(gnt));
                if (i >= 2) chk("cont_alternate", 32'(gnt), 32'(prev_g ^ N'(3)));
                prev_g = gnt;
            end
        end
        repeat (3) drive(N'(0), 5'd0, 5'd0);

`ifdef ROM_ARB_FIXED_PRIO_EN
        // fixed priority: req=111 held, requester 2 starves
        for (int i = 0; i < 9; i++) begin
            addr = '0;
            drive(N'(7), 5'd1, 5'd2);
            if (i >= 1) chk("fixed_pattern", 32'(gnt), (i % 2 == 1) ? 32'h1 : 32'h2);
        end
        repeat (3) drive(N'(0), 5'd0, 5'd0);
`endif

        // address wrap: addr0=31
        drive(N'(1), 5'd31, 5'd0);
        drive(N'(1), 5'd31, 5'd0);
        chk("wrap_addr", 32'(rom_address), 32'd31);
        drive(N'(0), 5'd0, 5'd0);
        chk("wrap_rdata", 32'(rdata), 32'hBA);
        drive(N'(0), 5'd0, 5'd0);

        // reset in the cycle gnt=01
        drive(N'(1), 5'd9, 5'd0);
        drive(N'(1), 5'd9, 5'd0);
        chk("mid_gnt_before", 32'(gnt), 32'h1);
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("mid_gnt_async", 32'(gnt), 32'h0);
        chk("mid_rvalid_async", 32'(rvalid), 32'h0);
        chk("mid_rdata_async", 32'(rdata), 32'h0);
        chk("mid_addr_async", 32'(rom_address), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        drive(N'(3), 5'd4, 5'd6);
        drive(N'(3), 5'd4, 5'd6);
        chk("mid_rearb_gnt", 32'(gnt), 32'h1);
        chk("mid_no_stale_rvalid", 32'(rvalid), 32'h0);
        drive(N'(2), 5'd0, 5'd6);
        chk("mid_rearb_gnt1", 32'(gnt), 32'h2);
        repeat (2) drive(N'(0), 5'd0, 5'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) rand_cycle(1'b1);
        for (int i = 0; i < 20; i++) rand_cycle(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("drain_gnt_queue", 32'(gq.size()), 32'd0);
        chk("drain_read_queue", 32'(rq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_read_arbiter.md
# rom_read_arbiter

Round-robin arbiter that shares the single-port 32x8 synchronous ROM between several read requesters, such as the binary-search engine and a display or scan engine. It sits between the requesters and the ROM instance, drives the ROM address, and returns ROM data tagged with a per-requester valid strobe. The ROM registers its address on the clock edge, so data returns one cycle after the address is presented. The arbiter hides that latency behind a simple req/gnt/rvalid handshake.

## Interface
Parameters:
- N_REQ, 2, number of requesters (2..8)
- ADDR_W, 5, ROM address width
- DATA_W, 8, ROM data width

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- reset_n  input  1  asynchronous, active-low reset
- req  input  N_REQ  per-requester read request, level, held until granted
- addr  input  N_REQ*ADDR_W  packed request addresses; requester i uses addr[i*ADDR_W +: ADDR_W]
- gnt  output  N_REQ  one-hot grant pulse, at most one bit set per cycle
- rvalid  output  N_REQ  one-hot read-data-valid pulse
- rdata  output  DATA_W  read data; rom_q when any rvalid bit is set, else 0
- rom_address  output  ADDR_W  registered address to the ROM
- rom_q  input  DATA_W  ROM output; valid one cycle after rom_address

## Operation
**State:**
- rr_ptr: log2(N_REQ) bits, the requester with the highest priority.
- gnt register.
- rom_address register.
- vld register: N_REQ bits, a one-cycle delayed copy of gnt.

**Arbitration (every cycle):**
- Eligible set = req & ~gnt. The requester granted this cycle is masked for one cycle, so its still-high req is not granted twice.
- Pick the first eligible requester, scanning upward from rr_ptr with wrap-around modulo N_REQ.

**On a winner w (registered at the edge):**
- gnt <= one-hot(w).
- rom_address <= addr of w.
- rr_ptr <= (w+1) mod N_REQ.

**No eligible requester:**
- gnt <= 0.
- rom_address and rr_ptr hold their values.

**Read return:** vld <= gnt every edge; rvalid = vld; rdata = (|vld) ? rom_q : 0.

**Requester contract:**
- Hold req and addr stable until gnt is seen high.
- Drop req on the edge that ends the gnt cycle.
- A req still high after that edge is a new request.

**Out-of-range parameters:** with N_REQ=1 the masking limits the sole requester to one grant every other cycle.

## Timing
**Reset (while reset_n is low):**
- gnt=0, rvalid=0, rdata=0, rom_address=0, rr_ptr=0, vld=0.
- Reset takes effect immediately, without waiting for a clock edge.

**Latency:**
- req asserted in cycle 0 with no contention: gnt high in cycle 1, rom_address valid in cycle 1.
- rvalid and rdata valid in cycle 2.

**Throughput and fairness:**
- One grant per cycle aggregate.
- A single requester gets at most one grant every 2 cycles.
- Under full load, each of N requesters is served within N cycles of the grant before its own.

**Simultaneous events:** the new request and the delivery of the previous read overlap with no bubble, so gnt and rvalid can both be high in the same cycle for different requesters.

**Reset mid-operation:**
- In-flight reads are squashed: no rvalid is produced for grants issued before reset.
- Requests still high after reset_n rises re-arbitrate from rr_ptr=0.

## Configuration
Macro `ROM_ARB_FIXED_PRIO_EN`:
- **Defined:** fixed priority; the lowest-index eligible requester always wins, and rr_ptr is removed.
- **Undefined (default):** round-robin as specified above.
- **Same in both modes:** masking, latency and reset behaviour.

## Test plan
The bench uses a ROM model with q = address XOR 8'hA5 and one-cycle latency. N_REQ=2 unless noted.

- **Single request:** reset release, then req[0]=1 with addr0=5'd7 in cycle 0 -> gnt=2'b01 in cycle 1, rom_address=7; rvalid=2'b01 and rdata=8'hA2 in cycle 2; all outputs 0 afterwards.
- **Contention:** req=2'b11 with addr0=3, addr1=20 held until granted -> gnt 01 then 10 on consecutive cycles; rdata 8'hA6 then 8'hB1 with rvalid 01 then 10.
- **Continuous contention:** req[1:0] held high for 10 cycles with round-robin -> gnt alternates 01,10,01,...; no requester is granted twice in a row.
- **Fixed priority:** with `ROM_ARB_FIXED_PRIO_EN` and N_REQ=3, req=3'b111 held -> gnt pattern 001,010,001,010,...; requester 2 is never granted while requesters 0 and 1 remain asserted.
- **Reset mid-read:** reset_n pulled low asynchronously in the cycle gnt=01 -> gnt, rvalid and rdata go to 0 at once, and no rvalid follows after release.
- **Address wrap:** addr0=5'd31 -> rom_address=31, rdata=8'hBA.
